// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and the neuron array / host.
// The master modport is the sequencer side; the slave modport is the side
// that issues go, reports neuron_ready and consumes the control strobes.
interface layer_sequencer_if #(
    parameter int L = 3
);
    localparam int IDX_W = (L > 1) ? $clog2(L) : 1;

    logic             go;
    logic             neuron_ready;
    logic             neuron_start;
    logic             res_ld;
    logic [IDX_W-1:0] layer_idx;
    logic             buf_sel;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  go,
        input  neuron_ready,
        output neuron_start,
        output res_ld,
        output layer_idx,
        output buf_sel,
        output busy,
        output done,
        output err
    );

    modport slave (
        output go,
        output neuron_ready,
        input  neuron_start,
        input  res_ld,
        input  layer_idx,
        input  buf_sel,
        input  busy,
        input  done,
        input  err
    );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps a neuron array through L layers per inference.
// For every layer it pulses neuron_start, waits for neuron_ready, strobes
// res_ld to capture the result, then advances layer_idx and flips the
// ping-pong buffer select. A single done pulse closes the inference.
//
// Optional feature: define LAYER_SEQ_WATCHDOG_EN to add a WAIT-state
// watchdog. After TIMEOUT WAIT cycles without neuron_ready the sequencer
// aborts through ERR, raising a sticky err flag (cleared by the next
// accepted go or by rst). Without the macro WAIT waits forever and err is 0.
//
// All control outputs are decoded from registered state, so the
// asynchronous reset drives them to 0 immediately.
module layer_sequencer #(
    parameter int L       = 3,
    parameter int N       = 10,
    parameter int TIMEOUT = N + 8
) (
    input  logic               clk,
    input  logic               rst,
    layer_sequencer_if.master  bus
);

    localparam int               IDX_W    = (L > 1) ? $clog2(L) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);

    // Reject configurations that cannot sequence anything.
    if (L < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("layer_sequencer: L and TIMEOUT must both be at least 1");
    end

`ifdef LAYER_SEQ_WATCHDOG_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    // Counter only needs to reach TIMEOUT-1 before the abort fires.
    localparam int               WDOG_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] layer_idx_q, layer_idx_d;
    logic             buf_sel_q, buf_sel_d;

    logic             neuron_start_o;
    logic             res_ld_o;
    logic             busy_o;
    logic             done_o;

    // State, layer index, buffer select (and watchdog) registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            layer_idx_q <= '0;
            buf_sel_q   <= 1'b0;
`ifdef LAYER_SEQ_WATCHDOG_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            buf_sel_q   <= buf_sel_d;
`ifdef LAYER_SEQ_WATCHDOG_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state logic and state-decoded control strobes.
    always_comb begin
        state_d        = state_q;
        layer_idx_d    = layer_idx_q;
        buf_sel_d      = buf_sel_q;
`ifdef LAYER_SEQ_WATCHDOG_EN
        wdog_d         = wdog_q;
        err_d          = err_q;
`endif
        neuron_start_o = 1'b0;
        res_ld_o       = 1'b0;
        busy_o         = 1'b1;
        done_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                // go is only looked at here, so requests while busy are dropped.
                if (bus.go) begin
                    state_d     = S_START;
                    layer_idx_d = '0;
                    buf_sel_d   = 1'b0;
`ifdef LAYER_SEQ_WATCHDOG_EN
                    wdog_d      = '0;
                    err_d       = 1'b0;
`endif
                end
            end

            S_START: begin
                neuron_start_o = 1'b1;
                state_d        = S_WAIT;
`ifdef LAYER_SEQ_WATCHDOG_EN
                // Every layer gets a fresh watchdog window.
                wdog_d         = '0;
`endif
            end

            S_WAIT: begin
`ifdef LAYER_SEQ_WATCHDOG_EN
                // A ready arriving on the expiry cycle still wins.
                if (bus.neuron_ready) begin
                    state_d = S_STORE;
                end else if (wdog_q == WDOG_LIMIT) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
`else
                if (bus.neuron_ready) begin
                    state_d = S_STORE;
                end
`endif
            end

            S_STORE: begin
                res_ld_o = 1'b1;
                if (layer_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                // Only reached when layer_idx_q < L-1, so no wrap is possible.
                layer_idx_d = layer_idx_q + 1'b1;
                buf_sel_d   = ~buf_sel_q;
                state_d     = S_START;
            end

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

`ifdef LAYER_SEQ_WATCHDOG_EN
            S_ERR: begin
                state_d = S_IDLE;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.neuron_start = neuron_start_o;
    assign bus.res_ld       = res_ld_o;
    assign bus.busy         = busy_o;
    assign bus.done         = done_o;
    assign bus.layer_idx    = layer_idx_q;
    assign bus.buf_sel      = buf_sel_q;
`ifdef LAYER_SEQ_WATCHDOG_EN
    assign bus.err          = err_q;
`else
    assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a 3-layer and a 1-layer instance share
// clock and reset. Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, away from the active edge.
module tb_layer_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    layer_sequencer_if #(.L(3)) bus3 ();
    layer_sequencer_if #(.L(1)) bus1 ();

    layer_sequencer #(.L(3), .N(10)) u_seq3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    layer_sequencer #(.L(1), .N(10)) u_seq1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse counters sampled on the falling edge.
    int starts3 = 0, lds3 = 0, dones3 = 0;
    int starts1 = 0, lds1 = 0, dones1 = 0;

    always @(negedge clk) begin
        if (bus3.neuron_start) starts3++;
        if (bus3.res_ld)       lds3++;
        if (bus3.done)         dones3++;
        if (bus1.neuron_start) starts1++;
        if (bus1.res_ld)       lds1++;
        if (bus1.done)         dones1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entry: sitting in the START cycle of layer idx on the 3-layer DUT.
    // Exit: START cycle of the next layer, or the IDLE cycle after DONE.
    task automatic run_layer3(input int idx, input logic bsel, input int delay);
        check("start_pulse", 32'(bus3.neuron_start), 1);
        check("start_idx",   32'(bus3.layer_idx), idx);
        check("start_buf",   32'(bus3.buf_sel), 32'(bsel));
        step();
        check("wait_no_start", 32'(bus3.neuron_start), 0);
        repeat (delay) step();
        check("wait_busy",  32'(bus3.busy), 1);
        check("wait_no_ld", 32'(bus3.res_ld), 0);
        bus3.neuron_ready = 1'b1;
        step();
        bus3.neuron_ready = 1'b0;
        check("store_ld",  32'(bus3.res_ld), 1);
        check("store_idx", 32'(bus3.layer_idx), idx);
        check("store_buf", 32'(bus3.buf_sel), 32'(bsel));
        $display("L3 layer %0d stored buf_sel=%0d", bus3.layer_idx, bus3.buf_sel);
        step();
        if (idx == 2) begin
            check("done_pulse", 32'(bus3.done), 1);
            check("done_idx",   32'(bus3.layer_idx), 2);
            step();
            check("idle_done_low", 32'(bus3.done), 0);
            check("idle_busy",     32'(bus3.busy), 0);
            check("idle_idx_hold", 32'(bus3.layer_idx), 2);
        end else begin
            check("next_busy",     32'(bus3.busy), 1);
            check("next_no_start", 32'(bus3.neuron_start), 0);
            check("next_no_ld",    32'(bus3.res_ld), 0);
            step();
        end
    endtask

    initial begin
        int s0, l0, d0;

        bus3.go = 1'b0; bus3.neuron_ready = 1'b0;
        bus1.go = 1'b0; bus1.neuron_ready = 1'b0;

        // Reset state
        step(); step();
        check("rst_busy",  32'(bus3.busy), 0);
        check("rst_start", 32'(bus3.neuron_start), 0);
        check("rst_ld",    32'(bus3.res_ld), 0);
        check("rst_idx",   32'(bus3.layer_idx), 0);
        check("rst_buf",   32'(bus3.buf_sel), 0);
        check("rst_done",  32'(bus3.done), 0);
        check("rst_err",   32'(bus3.err), 0);
        rst = 1'b0;
        step();
        check("idle_no_go", 32'(bus3.busy), 0);

        // Three-layer inference, ready 13 cycles after each start
        s0 = starts3; l0 = lds3; d0 = dones3;
        bus3.go = 1'b1;
        step();
        bus3.go = 1'b0;
        check("go_busy", 32'(bus3.busy), 1);
        run_layer3(0, 1'b0, 12);
        run_layer3(1, 1'b1, 12);
        run_layer3(2, 1'b0, 12);
        check("l3_starts", 32'(starts3 - s0), 3);
        check("l3_lds",    32'(lds3 - l0), 3);
        check("l3_dones",  32'(dones3 - d0), 1);
        $display("L3 inference complete");

        // Single-layer inference, ready after 5 cycles
        s0 = starts1; l0 = lds1; d0 = dones1;
        bus1.go = 1'b1;
        step();
        bus1.go = 1'b0;
        check("l1_start", 32'(bus1.neuron_start), 1);
        step();
        repeat (4) step();
        bus1.neuron_ready = 1'b1;
        step();
        bus1.neuron_ready = 1'b0;
        check("l1_ld",     32'(bus1.res_ld), 1);
        check("l1_idx",    32'(bus1.layer_idx), 0);
        check("l1_buf_ld", 32'(bus1.buf_sel), 0);
        step();
        check("l1_done",     32'(bus1.done), 1);
        check("l1_buf_done", 32'(bus1.buf_sel), 0);
        step();
        check("l1_idle", 32'(bus1.busy), 0);
        check("l1_starts", 32'(starts1 - s0), 1);
        check("l1_lds",    32'(lds1 - l0), 1);
        check("l1_dones",  32'(dones1 - d0), 1);
        $display("L1 inference complete");

        // go held high: one inference per IDLE visit, ready in START ignored
        s0 = starts3;
        bus3.go = 1'b1;
        step();
        check("hold_start", 32'(bus3.neuron_start), 1);
        bus3.neuron_ready = 1'b1;
        step();
        bus3.neuron_ready = 1'b0;
        check("spur_no_ld", 32'(bus3.res_ld), 0);
        check("spur_wait",  32'(bus3.busy), 1);
        step();
        check("spur_still_wait", 32'(bus3.res_ld), 0);
        bus3.neuron_ready = 1'b1;
        step();
        bus3.neuron_ready = 1'b0;
        check("hold_ld0", 32'(bus3.res_ld), 1);
        step();
        step();
        run_layer3(1, 1'b1, 3);
        run_layer3(2, 1'b0, 3);
        check("hold_one_inference", 32'(starts3 - s0), 3);
        step();
        check("hold_restart",     32'(bus3.neuron_start), 1);
        check("hold_restart_idx", 32'(bus3.layer_idx), 0);
        bus3.go = 1'b0;
        $display("L3 held-go inference complete, second started");

        // Asynchronous reset in WAIT of layer 1
        run_layer3(0, 1'b0, 2);
        step();
        check("pre_rst_idx", 32'(bus3.layer_idx), 1);
        d0 = dones3;
        #2 rst = 1'b1;
        #1;
        check("arst_busy",  32'(bus3.busy), 0);
        check("arst_idx",   32'(bus3.layer_idx), 0);
        check("arst_buf",   32'(bus3.buf_sel), 0);
        check("arst_start", 32'(bus3.neuron_start), 0);
        check("arst_ld",    32'(bus3.res_ld), 0);
        check("arst_done",  32'(bus3.done), 0);
        check("arst_err",   32'(bus3.err), 0);
        step(); step();
        rst = 1'b0;
        step();
        check("arst_no_done", 32'(dones3 - d0), 0);
        bus3.go = 1'b1;
        step();
        bus3.go = 1'b0;
        run_layer3(0, 1'b0, 1);
        run_layer3(1, 1'b1, 1);
        run_layer3(2, 1'b0, 1);
        $display("L3 restart after reset complete");

        // Watchdog behaviour
        bus3.go = 1'b1;
        step();
        bus3.go = 1'b0;
        step();
`ifdef LAYER_SEQ_WATCHDOG_EN
        repeat (17) step();
        check("wd_wait18_busy", 32'(bus3.busy), 1);
        check("wd_wait18_err",  32'(bus3.err), 0);
        step();
        check("wd_err_set",  32'(bus3.err), 1);
        step();
        check("wd_busy_low", 32'(bus3.busy), 0);
        check("wd_err_idle", 32'(bus3.err), 1);
        check("wd_no_done",  32'(bus3.done), 0);
        step(); step();
        check("wd_err_sticky", 32'(bus3.err), 1);
        bus3.go = 1'b1;
        step();
        bus3.go = 1'b0;
        check("wd_go_clears", 32'(bus3.err), 0);
        step();
        repeat (17) step();
        bus3.neuron_ready = 1'b1;
        step();
        bus3.neuron_ready = 1'b0;
        check("wd_expiry_ld",  32'(bus3.res_ld), 1);
        check("wd_expiry_err", 32'(bus3.err), 0);
        $display("L3 watchdog expiry and ready-priority exercised");
`else
        repeat (40) step();
        check("nowd_busy",  32'(bus3.busy), 1);
        check("nowd_err",   32'(bus3.err), 0);
        check("nowd_no_ld", 32'(bus3.res_ld), 0);
        bus3.neuron_ready = 1'b1;
        step();
        bus3.neuron_ready = 1'b0;
        check("nowd_ld", 32'(bus3.res_ld), 1);
        $display("L3 long wait without watchdog exercised");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter L, default 3: number of layers sequenced per inference (L >= 1).
REQ-002 Parameter N, default 10: inputs per neuron, matching the neuron datapath.
REQ-003 Parameter TIMEOUT, default N+8: watchdog limit in WAIT cycles.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 go  input  1  request one inference; sampled only in IDLE.
REQ-007 neuron_ready  input  1  neuron-array completion indication, honoured only in WAIT.
REQ-008 neuron_start  output  1  one-cycle start pulse to the neuron array.
REQ-009 res_ld  output  1  one-cycle load strobe capturing the layer result into the buffer.
REQ-010 layer_idx  output  max(1,$clog2(L))  index of the layer in progress.
REQ-011 buf_sel  output  1  ping-pong buffer select (read side = buf_sel, write side = ~buf_sel).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when all L layers are complete.
REQ-014 err  output  1  sticky watchdog error flag.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT, STORE, NEXT, DONE (plus ERR under REQ-027).
REQ-016 IDLE: go=1 -> START; layer_idx, buf_sel and the watchdog counter are cleared; err is cleared.
REQ-017 IDLE: go=0 -> remain in IDLE.
REQ-018 START: neuron_start=1 for exactly this one cycle; unconditional -> WAIT.
REQ-019 WAIT: neuron_ready=1 -> STORE; otherwise remain in WAIT.
REQ-020 STORE: res_ld=1 for one cycle; layer_idx==L-1 -> DONE, else -> NEXT.
REQ-021 NEXT: layer_idx increments by 1 and buf_sel toggles at the exit edge; -> START.
REQ-022 DONE: done=1 for one cycle; -> IDLE; layer_idx holds L-1 until the next go.
REQ-023 go while busy SHALL be ignored, with no queuing; neuron_ready outside WAIT SHALL be ignored.
REQ-024 Latency: go sampled at edge k -> neuron_start high in cycle k+1; per layer, neuron_ready sampled at edge j -> res_ld high in cycle j+1.
REQ-025 For L=1, NEXT SHALL never be entered and buf_sel SHALL stay 0.
REQ-026 layer_idx SHALL never exceed L-1; there is no wrap-around within an inference.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, layer_idx=0, buf_sel=0, watchdog=0, and all outputs to 0 (err=0), including mid-inference; no done pulse is emitted on reset.

Configuration
REQ-028 Macro LAYER_SEQ_WATCHDOG_EN defined: a counter increments each WAIT cycle and clears on entering WAIT.
REQ-029 With LAYER_SEQ_WATCHDOG_EN defined, count reaching TIMEOUT-1 with neuron_ready=0 -> ERR; ERR sets err=1 and returns to IDLE next cycle with no done pulse.
REQ-030 With LAYER_SEQ_WATCHDOG_EN defined, neuron_ready=1 on the same cycle as expiry SHALL take priority (-> STORE, no error).
REQ-031 With LAYER_SEQ_WATCHDOG_EN defined, err SHALL stay 1 until the next accepted go or rst.
REQ-032 Macro LAYER_SEQ_WATCHDOG_EN undefined: no counter and no ERR state; WAIT waits indefinitely; err is tied to 0.

Verification
REQ-033 L=3, go pulse, neuron_ready 13 cycles after each neuron_start -> 3 neuron_start, 3 res_ld, layer_idx 0,1,2, buf_sel 0,1,0, then one done pulse and busy=0.
REQ-034 L=1, go, neuron_ready after 5 cycles -> one neuron_start, one res_ld, done pulse, buf_sel stays 0.
REQ-035 go held high throughout a 3-layer inference -> exactly one inference per IDLE visit; a second starts only after done; spurious neuron_ready in START ignored.
REQ-036 rst asserted in WAIT of layer 1 -> all outputs 0 asynchronously, no done pulse; the next go restarts at layer_idx=0.
REQ-037 LAYER_SEQ_WATCHDOG_EN, TIMEOUT=18, neuron_ready withheld -> err=1 after 18 WAIT cycles and busy falls; ready on the expiry cycle -> res_ld, err stays 0; the next go clears err.
